// File: rtl/log2_frac_iter.sv
// Sequential fixed-point log2: integer part from the operand's MSB index,
// fractional part by repeated squaring of the normalized mantissa, one bit per cycle.
module log2_frac_iter #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 8,
    localparam int IW       = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IW-1:0]        out_int,
    output logic [FRAC_BITS-1:0] out_frac,
    output logic                 out_zero
);

    localparam int CW = (FRAC_BITS > 1) ? $clog2(FRAC_BITS) : 1;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        int_q, int_d;
    logic [FRAC_BITS-1:0] frac_q, frac_d;
    logic                 zero_q, zero_d;

    logic [IW-1:0]        msb;
    logic [WIDTH-1:0]     norm;
    logic [2*WIDTH-1:0]   prod;
    logic                 sq_bit;
    logic [WIDTH-1:0]     m_next;
    logic                 unused_lo;

    always_comb begin
        msb = '0;
        for (int i = 0; i < WIDTH; i++)
            if (in_data[i]) msb = IW'(i);
    end

    // Shift the leading one up to bit WIDTH-1 so the mantissa reads as 1.f.
    assign norm = in_data << (IW'(WIDTH - 1) - msb);

    // m in [1,2) squared lands in [1,4); the top bit says whether it crossed 2.
    assign prod      = {{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, m_q};
    assign sq_bit    = prod[2*WIDTH-1];
    assign m_next    = sq_bit ? prod[2*WIDTH-1 -: WIDTH] : prod[2*WIDTH-2 -: WIDTH];
    assign unused_lo = ^prod[WIDTH-2:0];

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        int_d   = int_q;
        frac_d  = frac_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    frac_d = '0;
                    if (in_data == '0) begin
                        zero_d  = 1'b1;
                        int_d   = '0;
                        state_d = DONE;
                    end else begin
                        zero_d  = 1'b0;
                        int_d   = msb;
                        m_d     = norm;
                        cnt_d   = '0;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                frac_d = (frac_q << 1) | FRAC_BITS'(sq_bit);
                m_d    = m_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(FRAC_BITS - 1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            cnt_q   <= '0;
            int_q   <= '0;
            frac_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
            frac_q  <= frac_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_int   = int_q;
    assign out_frac  = frac_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_log2_frac_iter.sv
// Directed and randomized checks of log2_frac_iter against a real-arithmetic log2 model.
module tb_log2_frac_iter;
    localparam int W  = 32;
    localparam int F  = 8;
    localparam int IW = 5;
    localparam int N  = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_int;
    logic [F-1:0]  out_frac;
    logic          out_zero;

    int checks = 0;
    int errors = 0;

    log2_frac_iter #(.WIDTH(W), .FRAC_BITS(F)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_int(out_int), .out_frac(out_frac), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] x, input int ei, input int ef, input bit ez, input int elat);
        int lat;
        @(negedge clk);
        chk($sformatf("rdy_before x=%0h", x), in_ready, 1);
        in_valid = 1; in_data = x; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        wait_valid(lat);
        chk($sformatf("latency x=%0h", x), lat, elat);
        chk($sformatf("int x=%0h", x), out_int, ei);
        chk($sformatf("frac x=%0h", x), out_frac, ef);
        chk($sformatf("zero x=%0h", x), out_zero, ez);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("rdy_after x=%0h", x), in_ready, 1);
        chk($sformatf("vld_after x=%0h", x), out_valid, 0);
    endtask

    // Reference: log2 computed in real arithmetic; the unit truncates, so it may sit 1 LSB low.
    task automatic check_model(input logic [31:0] x);
        int  e;
        real rr;
        int  lo, hi;
        if (x == 0) begin
            chk("rnd_zero0", out_zero, 1);
            chk("rnd_int0", out_int, 0);
            chk("rnd_frac0", out_frac, 0);
        end else begin
            e = 0;
            while ((64'd1 << (e + 1)) <= 64'(x)) e++;
            rr = ($ln(real'(longint'(x))) / $ln(2.0) - real'(e)) * 256.0;
            hi = int'($floor(rr + 1e-6));
            lo = int'($floor(rr - 1e-6)) - 1;
            chk($sformatf("rnd_int x=%0h", x), out_int, e);
            chk($sformatf("rnd_zero x=%0h", x), out_zero, 0);
            chk($sformatf("rnd_frac x=%0h frac=%0h lo=%0d hi=%0d", x, out_frac, lo, hi),
                (int'(out_frac) >= lo) && (int'(out_frac) <= hi), 1);
        end
    endtask

    function automatic logic [31:0] gen();
        if ($urandom_range(0, 15) == 0) return 32'd0;
        return $urandom >> $urandom_range(0, 31);
    endfunction

    initial begin
        logic [31:0] q[$];
        logic [31:0] pend;
        logic [31:0] got;
        bit          have;
        bit          seen;
        int          n_in, n_out, cyc, lat;

        rst = 1; in_valid = 0; in_data = '0; out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_int", out_int, 0);
        chk("rst_frac", out_frac, 0);
        chk("rst_zero", out_zero, 0);
        rst = 0;

        run_op(32'h1,        0,  8'h00, 0, F);
        run_op(32'h80000000, 31, 8'h00, 0, F);
        run_op(32'h00010000, 16, 8'h00, 0, F);
        run_op(32'h3,        1,  8'h95, 0, F);
        run_op(32'h5,        2,  8'h52, 0, F);
        run_op(32'hFFFFFFFF, 31, 8'hFF, 0, F);
        run_op(32'h0,        0,  8'h00, 1, 0);

        // Backpressure: x=5 waits on in_valid while the x=3 result is stalled.
        @(negedge clk);
        in_valid = 1; in_data = 3; out_ready = 0;
        @(posedge clk); #1;
        in_data = 5;
        wait_valid(lat);
        chk("bp_latency", lat, F);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_int", out_int, 1);
            chk("bp_frac", out_frac, 8'h95);
            chk("bp_ready", in_ready, 0);
            @(posedge clk);
        end
        @(negedge clk);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        @(negedge clk);
        chk("bp_ready_idle", in_ready, 1);
        chk("bp_valid_idle", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 0; out_ready = 1;
        wait_valid(lat);
        chk("bp2_latency", lat, F);
        chk("bp2_int", out_int, 2);
        chk("bp2_frac", out_frac, 8'h52);
        @(posedge clk);

        // Reset during ITER discards the operation.
        @(negedge clk);
        in_valid = 1; in_data = 5;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_int", out_int, 0);
        chk("mid_rst_frac", out_frac, 0);
        chk("mid_rst_zero", out_zero, 0);
        rst = 0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("mid_rst_no_result", seen, 0);
        run_op(32'h1, 0, 8'h00, 0, F);

        // Random sweep with random handshake gaps and a scoreboard queue.
        have = 0; n_in = 0; n_out = 0; cyc = 0; pend = '0;
        while (n_out < N && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (!have && n_in < N && $urandom_range(0, 3) != 0) begin
                pend = gen();
                have = 1;
            end
            in_valid  = have;
            in_data   = have ? pend : $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                chk("rnd_no_dup", q.size() > 0, 1);
                if (q.size() > 0) begin
                    got = q.pop_front();
                    check_model(got);
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                q.push_back(pend);
                have = 0;
                n_in++;
            end
            @(posedge clk);
        end
        chk("rnd_count", n_out, N);
        chk("rnd_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
